// File: rtl/uart_tx_sched.sv
// UART transmit FIFO controller: round-robin write arbitration between two
// byte requesters, registered-read drain into the transmitter, and flush.
module uart_tx_sched #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_req0_valid,
   input  logic [WIDTH-1:0]     i_req0_data,
   output logic                 o_req0_ready,
   input  logic                 i_req1_valid,
   input  logic [WIDTH-1:0]     i_req1_data,
   output logic                 o_req1_ready,
   output logic                 o_fifo_wr_en,
   output logic [WIDTH-1:0]     o_fifo_wr_data,
   input  logic                 i_fifo_full,
   output logic                 o_fifo_rd_en,
   input  logic [WIDTH-1:0]     i_fifo_rd_data,
   input  logic                 i_fifo_rd_valid,
   input  logic                 i_fifo_empty,
   output logic                 o_tx_valid,
   output logic [WIDTH-1:0]     o_tx_data,
   input  logic                 i_tx_ready,
   input  logic                 i_flush,
   output logic                 o_busy,
   output logic [CNT_WIDTH-1:0] o_tx_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RDWAIT = 2'd1,
      S_HOLD   = 2'd2,
      S_FLUSH  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 ptr_q, ptr_d;
   logic [WIDTH-1:0]     hold_q, hold_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 rd_en;
   logic                 flushing;
   logic                 grant0, grant1;
   logic                 acc0, acc1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         ptr_q   <= 1'b0;
         hold_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
      end
   end

   // Drain FSM: one read per byte, flush preempts any held byte.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      rd_en   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_flush) begin
               state_d = S_FLUSH;
            end else if (!i_fifo_empty) begin
               rd_en   = 1'b1;
               state_d = S_RDWAIT;
            end
         end
         S_RDWAIT: begin
            if (i_flush) begin
               state_d = S_FLUSH;
            end else if (i_fifo_rd_valid) begin
               hold_d  = i_fifo_rd_data;
               state_d = S_HOLD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HOLD: begin
            if (i_flush) begin
               state_d = S_FLUSH;
            end else if (i_tx_ready) begin
               cnt_d   = cnt_q + CNT_WIDTH'(1);
               state_d = S_IDLE;
            end
         end
         S_FLUSH: begin
            rd_en = !i_fifo_empty;
            if (i_fifo_empty) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Round-robin write arbitration; pointer flips only on an accepted write.
   always_comb begin
      flushing = i_flush | (state_q == S_FLUSH);
      grant0   = i_req0_valid & (~i_req1_valid | ~ptr_q);
      grant1   = i_req1_valid & ~grant0;
      acc0     = grant0 & ~i_fifo_full & ~flushing & ~i_rst;
      acc1     = grant1 & ~i_fifo_full & ~flushing & ~i_rst;
      ptr_d    = ptr_q;
      if (acc0) begin
         ptr_d = 1'b1;
      end else if (acc1) begin
         ptr_d = 1'b0;
      end
   end

   assign o_req0_ready   = acc0;
   assign o_req1_ready   = acc1;
   assign o_fifo_wr_en   = acc0 | acc1;
   assign o_fifo_wr_data = i_rst ? '0 : (grant1 ? i_req1_data : i_req0_data);
   assign o_fifo_rd_en   = rd_en & ~i_rst;
   assign o_tx_valid     = (state_q == S_HOLD);
   assign o_tx_data      = hold_q;
   assign o_tx_count     = cnt_q;
   assign o_busy         = ~i_rst & ((state_q != S_IDLE) | ~i_fifo_empty);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: table of arbitration vectors against a forced
// FIFO status, then directed sequences against a small FIFO model.
module tb_uart_tx_sched;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned CW    = 16;
   localparam int unsigned DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             r0_valid = 1'b0, r1_valid = 1'b0;
   logic [WIDTH-1:0] r0_data = '0, r1_data = '0;
   logic             r0_ready, r1_ready;
   logic             wr_en, rd_en;
   logic [WIDTH-1:0] wr_data, rd_data;
   logic             fifo_full, fifo_empty, rd_valid;
   logic             tx_valid, tx_ready = 1'b0, flush = 1'b0, busy;
   logic [WIDTH-1:0] tx_data;
   logic [CW-1:0]    tx_count;
   logic             manual = 1'b1, t_full = 1'b0;

   int n_vec = 0, n_err = 0, cyc_n = 0;

   always #5 clk = ~clk;

   uart_tx_sched #(.WIDTH(WIDTH), .CNT_WIDTH(CW)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0_valid(r0_valid), .i_req0_data(r0_data), .o_req0_ready(r0_ready),
      .i_req1_valid(r1_valid), .i_req1_data(r1_data), .o_req1_ready(r1_ready),
      .o_fifo_wr_en(wr_en), .o_fifo_wr_data(wr_data), .i_fifo_full(fifo_full),
      .o_fifo_rd_en(rd_en), .i_fifo_rd_data(rd_data), .i_fifo_rd_valid(rd_valid),
      .i_fifo_empty(fifo_empty),
      .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(tx_ready),
      .i_flush(flush), .o_busy(busy), .o_tx_count(tx_count)
   );

   // FIFO model: registered read, one-cycle latency, length-based flags.
   logic [WIDTH-1:0] mem [DEPTH];
   int unsigned      m_len;
   logic [2:0]       wp, rp;
   logic             m_rv;
   logic [WIDTH-1:0] m_rd;
   wire              m_wr    = wr_en && (m_len != DEPTH);
   wire              m_rd_ok = rd_en && (m_len != 0);

   always @(posedge clk) begin
      if (rst || manual) begin
         m_len <= 0; wp <= '0; rp <= '0; m_rv <= 1'b0; m_rd <= '0;
      end else begin
         m_rv <= m_rd_ok;
         if (m_rd_ok) begin
            m_rd <= mem[rp];
            rp   <= 3'(rp + 3'd1);
         end
         if (m_wr) begin
            mem[wp] <= wr_data;
            wp      <= 3'(wp + 3'd1);
         end
         m_len <= m_len + (m_wr ? 1 : 0) - (m_rd_ok ? 1 : 0);
      end
   end

   assign fifo_empty = manual ? 1'b1 : (m_len == 0);
   assign fifo_full  = manual ? t_full : (m_len == DEPTH);
   assign rd_valid   = manual ? 1'b0 : m_rv;
   assign rd_data    = m_rd;

   // Samples taken at the falling edge of the last cycle
   logic             s_acc0, s_acc1, s_wr, s_rd, s_txv, s_busy;
   logic [WIDTH-1:0] s_wd, s_txd;
   logic [CW-1:0]    s_cnt;
   logic [WIDTH-1:0] tx_q[$], wr_q[$];
   int               tx_t[$];
   int               txv_cycles = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc_n);
      end
   endtask

   // One clock: sample at negedge, then advance accepted requester data.
   task automatic cyc();
      @(negedge clk);
      s_acc0 = r0_ready; s_acc1 = r1_ready;
      s_wr = wr_en; s_wd = wr_data; s_rd = rd_en;
      s_txv = tx_valid; s_txd = tx_data; s_busy = busy; s_cnt = tx_count;
      if (wr_en) wr_q.push_back(wr_data);
      if (tx_valid) txv_cycles++;
      if (tx_valid && tx_ready) begin
         tx_q.push_back(tx_data);
         tx_t.push_back(cyc_n);
      end
      @(posedge clk);
      #1;
      cyc_n++;
      if (s_acc0) r0_data = WIDTH'(r0_data + 8'd1);
      if (s_acc1) r1_data = WIDTH'(r1_data + 8'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0; flush = 1'b0; tx_ready = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_txv"}, 32'(s_txv), 32'd0);
      chk({tag, "_txd"}, 32'(s_txd), 32'd0);
      chk({tag, "_cnt"}, 32'(s_cnt), 32'd0);
      chk({tag, "_busy"}, 32'(s_busy), 32'd0);
      chk({tag, "_rd"}, 32'(s_rd), 32'd0);
      chk({tag, "_wr"}, 32'(s_wr), 32'd0);
   endtask

   typedef struct {
      logic v0; logic [7:0] d0; logic v1; logic [7:0] d1; logic full; logic fl;
      logic e_r0; logic e_r1; logic e_wr; logic [7:0] e_wd; logic e_busy;
   } vec_t;
   vec_t vt [11];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_n);
      $fatal(1);
   end

   initial begin
      int acc;
      vt[0]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
      vt[1]  = '{1'b1, 8'h33, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0};
      vt[2]  = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0};
      vt[3]  = '{1'b1, 8'h44, 1'b1, 8'h45, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 1'b0};
      vt[4]  = '{1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0};
      vt[5]  = '{1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h66, 1'b0};
      vt[6]  = '{1'b1, 8'h70, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0};
      vt[7]  = '{1'b1, 8'h80, 1'b1, 8'h88, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h88, 1'b1};
      vt[8]  = '{1'b1, 8'h90, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h99, 1'b0};
      vt[9]  = '{1'b0, 8'hAA, 1'b0, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b0};
      vt[10] = '{1'b1, 8'hC0, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hC0, 1'b0};

      // Reset state with FIFO status forced empty
      manual = 1'b1;
      do_reset();
      cyc();
      chk_idle_zero("rst");

      // Arbitration table
      for (int i = 0; i < 11; i++) begin
         r0_valid = vt[i].v0; r0_data = vt[i].d0;
         r1_valid = vt[i].v1; r1_data = vt[i].d1;
         t_full = vt[i].full; flush = vt[i].fl;
         cyc();
         chk($sformatf("vec%0d_r0", i), 32'(s_acc0), 32'(vt[i].e_r0));
         chk($sformatf("vec%0d_r1", i), 32'(s_acc1), 32'(vt[i].e_r1));
         chk($sformatf("vec%0d_wr", i), 32'(s_wr), 32'(vt[i].e_wr));
         chk($sformatf("vec%0d_wd", i), 32'(s_wd), 32'(vt[i].e_wd));
         chk($sformatf("vec%0d_busy", i), 32'(s_busy), 32'(vt[i].e_busy));
      end
      r0_valid = 1'b0; r1_valid = 1'b0; flush = 1'b0; t_full = 1'b0;

      // Three bytes through with transmitter always ready
      manual = 1'b0;
      do_reset();
      tx_q.delete(); tx_t.delete(); txv_cycles = 0;
      tx_ready = 1'b1;
      r0_data = 8'h41; r0_valid = 1'b1; acc = 0;
      for (int i = 0; i < 20 && acc < 3; i++) begin
         cyc();
         if (s_acc0) acc++;
         if (acc == 3) r0_valid = 1'b0;
      end
      r0_valid = 1'b0;
      chk("seqA_writes", 32'(acc), 32'd3);
      for (int i = 0; i < 15; i++) cyc();
      chk("seqA_nbytes", 32'(tx_q.size()), 32'd3);
      if (tx_q.size() == 3) begin
         chk("seqA_b0", 32'(tx_q[0]), 32'h41);
         chk("seqA_b1", 32'(tx_q[1]), 32'h42);
         chk("seqA_b2", 32'(tx_q[2]), 32'h43);
         chk("seqA_gap0", 32'(tx_t[1] - tx_t[0]), 32'd3);
         chk("seqA_gap1", 32'(tx_t[2] - tx_t[1]), 32'd3);
      end
      chk("seqA_valid_cycles", 32'(txv_cycles), 32'd3);
      chk("seqA_count", 32'(s_cnt), 32'd3);

      // Both requesters streaming, transmitter stalled, FIFO fills
      do_reset();
      wr_q.delete();
      r0_data = 8'hA0; r1_data = 8'hB0; r0_valid = 1'b1; r1_valid = 1'b1;
      for (int i = 0; i < 14; i++) cyc();
      chk("seqB_nwr", 32'(wr_q.size()), 32'd9);
      if (wr_q.size() >= 4) begin
         chk("seqB_w0", 32'(wr_q[0]), 32'hA0);
         chk("seqB_w1", 32'(wr_q[1]), 32'hB0);
         chk("seqB_w2", 32'(wr_q[2]), 32'hA1);
         chk("seqB_w3", 32'(wr_q[3]), 32'hB1);
      end
      cyc();
      chk("seqC_full_r0", 32'(s_acc0), 32'd0);
      chk("seqC_full_r1", 32'(s_acc1), 32'd0);
      chk("seqC_full_wr", 32'(s_wr), 32'd0);
      chk("seqC_hold_txd", 32'(s_txd), 32'hA0);
      tx_ready = 1'b1;
      acc = 0;
      for (int i = 0; i < 10 && acc == 0; i++) begin
         cyc();
         if (s_wr) begin
            acc = 1;
            chk("seqC_resume_wd", 32'(s_wd), 32'hB4);
         end
      end
      chk("seqC_resume_seen", 32'(acc), 32'd1);
      r0_valid = 1'b0; r1_valid = 1'b0;

      // Byte held for 10 stalled cycles, then accepted
      do_reset();
      r0_data = 8'h55; r0_valid = 1'b1;
      cyc();
      chk("seqD_wr", 32'(s_acc0), 32'd1);
      r0_valid = 1'b0;
      cyc(); cyc();
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk($sformatf("seqD_stall%0d", i), {23'd0, s_txv, s_txd}, {23'd0, 1'b1, 8'h55});
      end
      tx_ready = 1'b1;
      cyc();
      chk("seqD_accept", {23'd0, s_txv, s_txd}, {23'd0, 1'b1, 8'h55});
      tx_ready = 1'b0;
      cyc();
      chk("seqD_count", 32'(s_cnt), 32'd1);
      chk("seqD_txv_low", 32'(s_txv), 32'd0);

      // Reset while waiting on read data
      r0_data = 8'h66; r0_valid = 1'b1;
      cyc();
      chk("seqF_wr", 32'(s_acc0), 32'd1);
      r0_valid = 1'b0;
      cyc();
      chk("seqF_rd", 32'(s_rd), 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      chk_idle_zero("seqF");
      r0_valid = 1'b1; r1_valid = 1'b1;
      cyc();
      chk("seqF_ptr_r0", 32'(s_acc0), 32'd1);
      chk("seqF_ptr_r1", 32'(s_acc1), 32'd0);
      r0_valid = 1'b0; r1_valid = 1'b0;

      // Flush with five queued bytes and one held
      do_reset();
      r0_data = 8'h10; r0_valid = 1'b1; acc = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (s_acc0) acc++;
      end
      r0_valid = 1'b0;
      chk("seqE_writes", 32'(acc), 32'd6);
      cyc(); cyc();
      chk("seqE_held", {23'd0, s_txv, s_txd}, {23'd0, 1'b1, 8'h10});
      r0_data = 8'h16; r0_valid = 1'b1; flush = 1'b1;
      cyc();
      chk("seqE_flush_r0", 32'(s_acc0), 32'd0);
      flush = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         cyc();
         chk($sformatf("seqE_f%0d_txv", i), 32'(s_txv), 32'd0);
         chk($sformatf("seqE_f%0d_rd", i), 32'(s_rd), (i <= 5) ? 32'd1 : 32'd0);
         chk($sformatf("seqE_f%0d_r0", i), 32'(s_acc0), 32'd0);
      end
      cyc();
      chk("seqE_exit_r0", 32'(s_acc0), 32'd1);
      chk("seqE_count", 32'(s_cnt), 32'd0);
      r0_valid = 1'b0;
      tx_ready = 1'b1;
      for (int i = 0; i < 6; i++) cyc();
      chk("seqE_after_count", 32'(s_cnt), 32'd1);
      tx_ready = 1'b0;

      // Reset during flush
      r0_data = 8'h20; r0_valid = 1'b1;
      cyc(); cyc(); cyc();
      r0_valid = 1'b0;
      cyc(); cyc(); cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      cyc();
      chk("seqG_flush_rd", 32'(s_rd), 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      chk_idle_zero("seqG");
      r0_valid = 1'b1; r1_valid = 1'b1;
      cyc();
      chk("seqG_ptr_r0", 32'(s_acc0), 32'd1);
      chk("seqG_ptr_r1", 32'(s_acc1), 32'd0);
      r0_valid = 1'b0; r1_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Controller for the UART transmit FIFO (synchronous, registered-read, 1-cycle read latency, len-based empty/full flags).
- Shares the FIFO write port between two byte requesters (CPU MMIO port, debug port) using round-robin arbitration.
- Drains the FIFO read port into the UART transmitter over a valid/ready handshake.
- Supports a flush command that discards all queued data.

Parameters:
- WIDTH, 8, data width of requesters, FIFO and transmitter.
- CNT_WIDTH, 16, width of the transmitted-byte counter.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req0_valid  in  1  requester 0 (CPU) has a byte
- i_req0_data  in  WIDTH  requester 0 byte
- o_req0_ready  out  1  requester 0 byte accepted this cycle when valid&ready
- i_req1_valid, i_req1_data, o_req1_ready  in/in/out  1/WIDTH/1  requester 1 (debug), same semantics
- o_fifo_wr_en  out  1  FIFO write strobe
- o_fifo_wr_data  out  WIDTH  FIFO write data
- i_fifo_full  in  1  FIFO full flag
- o_fifo_rd_en  out  1  FIFO read strobe
- i_fifo_rd_data  in  WIDTH  FIFO read data, valid one cycle after o_fifo_rd_en
- i_fifo_rd_valid  in  1  FIFO read-data qualifier
- i_fifo_empty  in  1  FIFO empty flag
- o_tx_valid  out  1  byte offered to transmitter
- o_tx_data  out  WIDTH  byte to transmitter
- i_tx_ready  in  1  transmitter accepts byte
- i_flush  in  1  single-cycle flush command
- o_busy  out  1  drain FSM not IDLE, or FIFO not empty
- o_tx_count  out  CNT_WIDTH  bytes handed to transmitter, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset: every output is 0, drain FSM is IDLE, round-robin pointer favours req0, o_tx_count is 0. Reset mid-transfer drops any held byte; reset has priority over all other inputs.
- Write arbitration (combinational readies, registered FIFO strobe not required):
  - grant0 = req0_valid & (~req1_valid | ptr==0); grant1 = req1_valid & ~grant0.
  - o_reqN_ready = grantN & ~i_fifo_full & ~flushing.
  - o_fifo_wr_en = OR of (valid & ready); o_fifo_wr_data is the granted requester's data.
  - After an accepted write, ptr points to the other requester. ptr is unchanged when nothing is accepted.
  - At most one write per cycle.
  - A write accepted in the same cycle the FIFO reaches DEPTH-1 is legal; full is seen the next cycle.
- Drain FSM states IDLE, RDWAIT, HOLD, FLUSH:
  - IDLE: if i_flush, go to FLUSH. Else if ~i_fifo_empty, pulse o_fifo_rd_en for 1 cycle and go to RDWAIT.
  - RDWAIT: capture i_fifo_rd_data into the hold register when i_fifo_rd_valid, then go to HOLD. i_fifo_rd_valid low here is a protocol error: return to IDLE with no output.
  - HOLD: o_tx_valid=1, o_tx_data = hold register. On i_tx_ready, increment o_tx_count and go to IDLE.
  - Minimum byte-to-byte period is 3 cycles.
  - o_fifo_rd_en is never asserted while i_fifo_empty=1.
- Flush:
  - i_flush in any state enters FLUSH the next cycle. Any byte in RDWAIT/HOLD is discarded and o_tx_valid drops.
  - FLUSH: o_fifo_rd_en = ~i_fifo_empty each cycle (back-to-back reads are legal); return data is ignored.
  - Requester readies are 0 (flushing=1) in FLUSH and in the cycle i_flush is high.
  - FLUSH exits to IDLE on the first cycle i_fifo_empty=1 with no read issued that cycle.
  - i_flush while already in FLUSH has no additional effect.
  - o_tx_count is not incremented by flushed bytes.
- Handshake rules: o_tx_data is stable while o_tx_valid=1 and i_tx_ready=0. o_tx_valid never drops without acceptance except on flush or reset.
- Simultaneous FIFO read and write in the same cycle is allowed; FIFO length is unchanged.

Test Plan:
- Reset, then req0 writes 0x41,0x42,0x43 with i_tx_ready=1 -> o_tx_data sequence 0x41,0x42,0x43, each o_tx_valid pulse 1 cycle, 3 cycles apart; o_tx_count=3.
- req0 and req1 both valid continuously with data 0xA0.. and 0xB0.. respectively, i_tx_ready=0 -> FIFO write order alternates A0,B0,A1,B1,...; first grant goes to req0.
- Fill the FIFO (i_fifo_full=1) with i_tx_ready=0 -> both readies 0, no o_fifo_wr_en; then assert i_tx_ready -> one byte drains and a write is accepted once full deasserts.
- Hold 0x55 in HOLD with i_tx_ready=0 for 10 cycles -> o_tx_valid=1 and o_tx_data=0x55 stable throughout; ready in cycle 11 -> accepted, count+1.
- 5 bytes queued plus 1 in HOLD, pulse i_flush -> o_tx_valid drops next cycle, 5 consecutive o_fifo_rd_en pulses, return to IDLE, o_tx_count unchanged, writes blocked until exit.
- Assert i_rst during RDWAIT and during FLUSH -> all outputs 0 next cycle, ptr favours req0, count 0.
